// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte
// sources, locking the grant for the length of a packet.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [8*NREQ-1:0]   req_data_i,
  input  logic [NREQ-1:0]     req_last_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic                uart_enabled_i,
  output logic                uart_dat_we_o,
  output logic [7:0]          uart_dat_o,
  input  logic                uart_dat_wait_i,
  output logic [NREQ-1:0]     grant_o,
  output logic                busy_o,
  output logic                lock_timeout_o,
  output logic [CNT_W-1:0]    tx_count_o
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic NOLOCK = (LOCK_TIMEOUT == 0);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [7:0]        hold_q, hold_d;
  logic              last_q, last_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PW-1:0]     win;
  logic [PW:0]       scan;
  logic              any_v;
  logic [7:0]        win_byte;
  logic [7:0]        own_byte;
  logic [NREQ-1:0]   ready;
  logic              tmo_fire;

  // Descending scan so the lowest offset from rr_q is the last to win.
  always_comb begin
    win   = rr_q;
    scan  = '0;
    any_v = |req_valid_i;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan = {1'b0, rr_q} + (PW+1)'(i);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (req_valid_i[scan[PW-1:0]]) win = scan[PW-1:0];
    end
  end

  assign win_byte = req_data_i[8*int'(win) +: 8];
  assign own_byte = req_data_i[8*int'(owner_q) +: 8];

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    last_d   = last_q;
    tmo_d    = tmo_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    ready    = '0;
    tmo_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (uart_enabled_i && any_v) begin
          ready   = ONE << win;
          hold_d  = win_byte;
          last_d  = req_last_i[win];
          owner_d = win;
          rr_d    = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          grant_d = ONE << win;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!uart_dat_wait_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_q || NOLOCK) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            state_d = LOCKED;
            tmo_d   = '0;
          end
        end
      end
      LOCKED: begin
        if (req_valid_i[owner_q] && uart_enabled_i) begin
          ready   = ONE << owner_q;
          hold_d  = own_byte;
          last_d  = req_last_i[owner_q];
          state_d = SEND;
        end else if (tmo_q == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
          grant_d  = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o    = ready;
  assign uart_dat_we_o  = (state_q == SEND);
  assign uart_dat_o     = (state_q == SEND) ? hold_q : 8'h00;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != IDLE);
  assign lock_timeout_o = tmo_fire;
  assign tx_count_o     = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, backpressure,
// round-robin, packet lock, lock timeout, counter wrap, reset, enable.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int LTO  = 8;
  localparam int CW   = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] valid;
  logic [31:0]     data;
  logic [NREQ-1:0] last;
  logic [NREQ-1:0] ready;
  logic            en;
  logic            we;
  logic [7:0]      dat;
  logic            wt;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            lto;
  logic [CW-1:0]   txc;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .LOCK_TIMEOUT(LTO),
    .CNT_W(CW)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .req_valid_i(valid),
    .req_data_i(data),
    .req_last_i(last),
    .req_ready_o(ready),
    .uart_enabled_i(en),
    .uart_dat_we_o(we),
    .uart_dat_o(dat),
    .uart_dat_wait_i(wt),
    .grant_o(grant),
    .busy_o(busy),
    .lock_timeout_o(lto),
    .tx_count_o(txc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  logic ok;

  initial begin
    rst   = 1'b1;
    valid = '0;
    data  = '0;
    last  = '0;
    en    = 1'b0;
    wt    = 1'b0;
    #1;
    check("rst_we", we, 0);
    check("rst_dat", dat, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_txc", txc, 0);
    check("rst_lto", lto, 0);
    nxt();
    rst = 1'b0;

    // single byte
    nxt();
    en = 1'b1; valid = 4'b0001; data[7:0] = 8'h41; last = 4'b0001;
    settle();
    check("sb_ready", ready, 4'b0001);
    check("sb_busy0", busy, 0);
    nxt();
    valid = '0;
    settle();
    check("sb_we", we, 1);
    check("sb_dat", dat, 8'h41);
    check("sb_grant", grant, 4'b0001);
    check("sb_ready_off", ready, 0);
    nxt();
    check("sb_we_off", we, 0);
    check("sb_txc", txc, 1);
    check("sb_grant_off", grant, 0);

    // backpressure
    valid = 4'b0010; data[15:8] = 8'h5A; last = 4'b0010; wt = 1'b1;
    settle();
    check("bp_ready", ready, 4'b0010);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nxt();
      valid = '0;
      settle();
      if (we !== 1'b1 || dat !== 8'h5A || ready !== '0 || txc !== 4'd1)
        ok = 1'b0;
    end
    check("bp_hold", ok, 1);
    nxt();
    wt = 1'b0;
    settle();
    check("bp_we_last", we, 1);
    nxt();
    check("bp_txc", txc, 2);
    check("bp_idle", busy, 0);

    // round-robin from a fresh pointer
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      nxt();
      valid = 4'b1111; last = 4'b1111;
      data = 32'h13121110;
      settle();
      check("rr_ready", ready, 4'b0001 << rr_exp[p]);
      nxt();
      check("rr_grant", grant, 4'b0001 << rr_exp[p]);
      check("rr_dat", dat, 8'h10 + rr_exp[p]);
    end

    // packet lock: req2 owns the UART for 3 bytes while req0 waits
    nxt();
    valid = 4'b0101; last = 4'b0001;
    data[23:16] = 8'hA0; data[7:0] = 8'hB0;
    settle();
    check("pl_ready0", ready, 4'b0100);
    nxt();
    check("pl_dat0", dat, 8'hA0);
    nxt();
    data[23:16] = 8'hA1;
    settle();
    check("pl_ready1", ready, 4'b0100);
    check("pl_grant1", grant, 4'b0100);
    nxt();
    check("pl_dat1", dat, 8'hA1);
    nxt();
    data[23:16] = 8'hA2; last = 4'b0101;
    settle();
    check("pl_ready2", ready, 4'b0100);
    nxt();
    check("pl_dat2", dat, 8'hA2);
    nxt();
    valid = 4'b0001;
    settle();
    check("pl_ready_r0", ready, 4'b0001);
    check("pl_grant_off", grant, 0);
    nxt();
    valid = '0;
    settle();
    check("pl_dat_r0", dat, 8'hB0);
    check("pl_grant_r0", grant, 4'b0001);
    nxt();
    check("pl_txc", txc, 9);

    // lock timeout: req3 goes quiet, req1 waits behind it
    valid = 4'b1000; last = 4'b0000; data[31:24] = 8'hC3;
    settle();
    check("to_ready3", ready, 4'b1000);
    nxt();
    valid = 4'b0010; last = 4'b0010; data[15:8] = 8'hD1;
    settle();
    check("to_dat3", dat, 8'hC3);
    for (int k = 0; k < 8; k++) begin
      nxt();
      check("to_grant", grant, 4'b1000);
      check("to_ready_blk", ready, 0);
      check("to_pulse", lto, (k == 7) ? 1 : 0);
    end
    nxt();
    check("to_pulse_off", lto, 0);
    check("to_ready1", ready, 4'b0010);
    check("to_grant_off", grant, 0);
    nxt();
    valid = '0;
    settle();
    check("to_dat1", dat, 8'hD1);

    // byte arriving on the expiry cycle wins over the timeout
    nxt();
    valid = 4'b1000; last = 4'b0000; data[31:24] = 8'hE3;
    settle();
    check("ex_ready3", ready, 4'b1000);
    nxt();
    valid = '0;
    settle();
    ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      nxt();
      if (lto !== 1'b0 || grant !== 4'b1000) ok = 1'b0;
    end
    check("ex_wait", ok, 1);
    nxt();
    valid = 4'b1000; last = 4'b1000; data[31:24] = 8'hE4;
    settle();
    check("ex_ready", ready, 4'b1000);
    check("ex_no_pulse", lto, 0);
    nxt();
    valid = '0;
    settle();
    check("ex_dat", dat, 8'hE4);
    nxt();
    check("ex_grant_off", grant, 0);
    check("ex_txc", txc, 13);

    // three more bytes wrap the 4-bit counter
    for (int j = 0; j < 3; j++) begin
      nxt();
      valid = 4'b0001; last = 4'b0001; data[7:0] = 8'h60 + 8'(j);
      settle();
      nxt();
      valid = '0;
    end
    nxt();
    check("wrap_txc", txc, 0);

    // reset in the middle of a stalled SEND
    nxt();
    valid = 4'b0001; data[7:0] = 8'h77; wt = 1'b1;
    settle();
    nxt();
    valid = '0;
    settle();
    check("mr_we_pre", we, 1);
    check("mr_dat_pre", dat, 8'h77);
    #1;
    rst = 1'b1;
    #1;
    check("mr_we", we, 0);
    check("mr_dat", dat, 0);
    check("mr_busy", busy, 0);
    check("mr_grant", grant, 0);
    check("mr_txc", txc, 0);
    nxt();
    rst = 1'b0; wt = 1'b0;

    // no acceptance while the UART is disabled
    en = 1'b0; valid = 4'b0001; last = 4'b0001; data[7:0] = 8'h88;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nxt();
      if (ready !== '0 || busy !== 1'b0) ok = 1'b0;
    end
    check("en_block", ok, 1);
    nxt();
    en = 1'b1;
    settle();
    check("en_ready", ready, 4'b0001);
    nxt();
    valid = '0;
    settle();
    check("en_dat", dat, 8'h88);
    nxt();
    check("en_txc", txc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single simple-UART transmitter between NREQ on-chip byte sources (for example the CPU log path, a debug bridge and a housekeeping engine).
- Arbitrates round-robin with packet locking, so a multi-byte message from one requester is never interleaved with bytes from another.
- Sequences the UART data-register write handshake: holds the write strobe until the transmitter stops signalling wait.
- Sits between the requesters and the UART core's data-write port, alongside the Wishbone UART wrapper.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- LOCK_TIMEOUT, 1024: cycles a locked grant waits for the owner's next byte before forced release. 0 disables locking, so every byte releases the grant.
- CNT_W, 16: width of the transmitted-byte counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NREQ  per-requester byte-valid.
- req_data_i  in  8*NREQ  packed bytes; requester k uses bits [8k+7:8k].
- req_last_i  in  NREQ  per-requester end-of-packet flag, qualified with valid.
- req_ready_o  out  NREQ  one-hot byte-accept strobe.
- uart_enabled_i  in  1  UART enable status.
- uart_dat_we_o  out  1  UART data write strobe.
- uart_dat_o  out  8  UART data byte.
- uart_dat_wait_i  in  1  UART transmitter busy; the write completes on an edge where we=1 and wait=0.
- grant_o  out  NREQ  one-hot current owner; all zero when unowned.
- busy_o  out  1  state is not IDLE.
- lock_timeout_o  out  1  one-cycle pulse on forced release.
- tx_count_o  out  CNT_W  bytes delivered to the UART; wraps.

Behaviour:
- Reset values (async assert, sync-clean deassert):
  - state=IDLE, rr_ptr=0, hold byte=0, hold_last=0, owner=0, timeout counter=0.
  - All outputs 0, including uart_dat_o=8'h00 and tx_count_o=0.
- The byte handshake is valid&ready. req_ready_o is combinational and asserts only for the selected requester in the cycle its byte is captured.
- IDLE:
  - Accepts a byte only when uart_enabled_i=1 and any req_valid_i is set.
  - Winner w = first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - In that cycle: req_ready_o[w]=1; capture data[w] and last[w]; owner<=w; rr_ptr<=(w+1) mod NREQ; next state SEND.
- SEND:
  - uart_dat_we_o=1 and uart_dat_o=hold byte, both held stable.
  - No new byte is accepted.
  - On an edge with uart_dat_wait_i=0 the byte is delivered: tx_count_o increments.
    - If hold_last=1 or LOCK_TIMEOUT=0: go to IDLE and clear grant_o.
    - Otherwise go to LOCKED with the timeout counter cleared.
  - Completes regardless of uart_enabled_i, because the byte is already owned by the arbiter.
- LOCKED:
  - grant_o stays on the owner. Other requesters' valids are ignored.
  - If req_valid_i[owner] and uart_enabled_i: ready[owner]=1, capture, next state SEND.
  - Otherwise the counter increments. When it reaches LOCK_TIMEOUT-1: lock_timeout_o pulses, state goes to IDLE and grant_o clears.
  - A byte arriving in the same cycle as expiry is accepted, and the timeout does not fire.
- grant_o is registered and equals the owner in SEND and LOCKED; busy_o=1 in SEND and LOCKED.
- Latency: valid in IDLE leads to we asserted the next cycle. Minimum 2 cycles per byte when wait=0.
- Single-requester streams are not starved by the UART: wait only stretches SEND.
- tx_count_o wraps from 2^CNT_W-1 to 0.
- Reset mid-SEND aborts the transfer: we drops immediately and the held byte is discarded.
- A requester dropping valid without a handshake is legal and has no effect.
- There is no acceptance while uart_enabled_i=0 in IDLE or LOCKED. The LOCKED timeout still counts during that time.

Test Plan:
- Single byte: req0 sends 8'h41 with last=1, wait=0. Expect ready[0] for 1 cycle, we high for 1 cycle with dat=8'h41, tx_count=1, return to IDLE, grant=0.
- UART backpressure: req1 sends 8'h5A while wait=1 for 20 cycles. Expect we held high and dat stable at 8'h5A all 20 cycles, ready[1] low throughout, tx_count increments exactly once after wait falls.
- Round-robin: requesters 0..3 continuously valid, each sending single-byte packets (last=1). Expect grant order 0,1,2,3,0 and no requester granted twice before the others.
- Packet lock: req2 sends 3 bytes, last on the third, while req0 is also valid. Expect all 3 of req2's bytes before any byte from req0, then req0 granted.
- Lock timeout with LOCK_TIMEOUT=8: req3 sends one byte with last=0 then goes idle. Expect lock_timeout_o to pulse once 8 cycles after entering LOCKED, then the pending req1 byte is granted.
- Reset and enable: assert wb_rst_i mid-SEND, expecting we=0 asynchronously and all outputs at reset values. Then hold uart_enabled_i=0 with req0 valid, expecting ready to stay 0 until enabled rises.
